// File: rtl/net_packet_loader_pkg.sv
// net_packet_loader_pkg: network packet format, core state and loader constants.
package net_packet_loader_pkg;

   localparam int ID_length_gp         = 19;
   localparam int imem_addr_width_gp   = 10;
   localparam int rd_size_gp           = 5;
   localparam int mask_length_gp       = 3;
   localparam int loader_fifo_depth_gp = 4;

   localparam logic [ID_length_gp-1:0] kNET_BCAST_ID = {ID_length_gp{1'b1}};

   typedef enum logic [2:0] {
      NET_NULL  = 3'd0,
      NET_INSTR = 3'd1,
      NET_REG   = 3'd2,
      NET_PC    = 3'd3,
      NET_BAR   = 3'd4
   } net_op_e;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_e;

   typedef enum logic {D_IDLE, D_HOLD} load_state_e;

   // Op is a raw 3-bit field so undefined codes 101..111 can travel the network.
   typedef struct packed {
      logic [ID_length_gp-1:0]       net_id;
      logic [2:0]                    net_op;
      logic [imem_addr_width_gp-1:0] net_addr;
      logic [31:0]                   net_data;
   } net_packet_s;

   function automatic logic op_valid(input logic [2:0] op);
      return op == NET_INSTR || op == NET_REG || op == NET_PC || op == NET_BAR;
   endfunction

endpackage

// File: rtl/net_packet_loader_if.sv
// net_packet_loader_if: valid/ready packet channel from the on-chip network.
interface net_packet_loader_if;
   import net_packet_loader_pkg::*;

   net_packet_s net_packet;
   logic        net_valid;
   logic        net_ready;

   modport master (output net_packet, output net_valid, input net_ready);
   modport slave  (input net_packet, input net_valid, output net_ready);

endinterface

// File: rtl/net_packet_loader_fifo.sv
// net_fifo: synchronous packet FIFO with registered count, full/empty flags.
module net_fifo
   import net_packet_loader_pkg::*;
#(
   parameter int DEPTH_P = loader_fifo_depth_gp
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enq_i,
   input  logic        deq_i,
   input  net_packet_s data_i,
   output net_packet_s data_o,
   output logic        full_o,
   output logic        empty_o
);
   localparam int AW = $clog2(DEPTH_P);

   net_packet_s   mem_q [DEPTH_P];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_enq, do_deq;

   assign full_o  = cnt_q == (AW+1)'(DEPTH_P);
   assign empty_o = cnt_q == '0;
   assign do_enq  = enq_i & ~full_o;
   assign do_deq  = deq_i & ~empty_o;
   assign data_o  = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (do_enq) mem_q[wr_q] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_enq) wr_q <= wr_q + AW'(1);
         if (do_deq) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_enq) - (AW+1)'(do_deq);
      end
   end

endmodule

// File: rtl/net_packet_loader.sv
// net_packet_loader: filters network packets by core ID, buffers them and dispatches write strobes.
// Define NET_BROADCAST_EN to also accept packets addressed to the all-ones broadcast ID.
module net_packet_loader
   import net_packet_loader_pkg::*;
#(
   parameter int FIFO_DEPTH_P = loader_fifo_depth_gp,
   parameter int DROP_CNT_W_P = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ID_length_gp-1:0]       core_id_i,
   input  state_e                        state_i,
   net_packet_loader_if.slave            net_if,
   output logic                          imem_wen_o,
   output logic [imem_addr_width_gp-1:0] imem_addr_o,
   output logic [15:0]                   imem_data_o,
   output logic                          rf_wen_o,
   output logic [rd_size_gp-1:0]         rf_addr_o,
   output logic [31:0]                   rf_data_o,
   output logic                          pc_wen_o,
   output logic [imem_addr_width_gp-1:0] pc_o,
   output logic                          bar_wen_o,
   output logic [mask_length_gp-1:0]     bar_mask_o,
   output logic [DROP_CNT_W_P-1:0]       drop_cnt_o
);
   localparam logic [0:0] ST_IDLE = D_IDLE;
   localparam logic [0:0] ST_HOLD = D_HOLD;

   net_packet_s                   head;
   logic                          full, empty, accept, id_match, enq, fire, stall, head_instr;
   logic [0:0]                    state_q, state_d;
   logic                          imem_wen_q, rf_wen_q, pc_wen_q, bar_wen_q;
   logic [imem_addr_width_gp-1:0] imem_addr_q, pc_q;
   logic [15:0]                   imem_data_q;
   logic [rd_size_gp-1:0]         rf_addr_q;
   logic [31:0]                   rf_data_q;
   logic [mask_length_gp-1:0]     bar_mask_q;
   logic [DROP_CNT_W_P-1:0]       drop_cnt_q;

   assign net_if.net_ready = ~full & ~reset;
   assign accept           = net_if.net_valid & net_if.net_ready;
`ifdef NET_BROADCAST_EN
   assign id_match = (net_if.net_packet.net_id == core_id_i) | (net_if.net_packet.net_id == kNET_BCAST_ID);
`else
   assign id_match = net_if.net_packet.net_id == core_id_i;
`endif
   assign enq = accept & id_match & op_valid(net_if.net_packet.net_op);

   net_fifo #(.DEPTH_P(FIFO_DEPTH_P)) fifo (
      .clk     (clk),
      .reset   (reset),
      .enq_i   (enq),
      .deq_i   (fire),
      .data_i  (net_if.net_packet),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   // The imem port belongs to fetch while running, so an INSTR head waits in D_HOLD.
   assign stall      = state_i == RUN;
   assign head_instr = head.net_op == NET_INSTR;
   assign fire       = ~empty & ((state_q == ST_HOLD) ? ~stall : ~(head_instr & stall));
   assign state_d    = (state_q == ST_HOLD) ? (stall ? ST_HOLD : ST_IDLE)
                     : (~empty & head_instr & stall) ? ST_HOLD : ST_IDLE;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         imem_wen_q  <= 1'b0;
         rf_wen_q    <= 1'b0;
         pc_wen_q    <= 1'b0;
         bar_wen_q   <= 1'b0;
         imem_addr_q <= '0;
         imem_data_q <= '0;
         rf_addr_q   <= '0;
         rf_data_q   <= '0;
         pc_q        <= '0;
         bar_mask_q  <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         imem_wen_q <= fire & (head.net_op == NET_INSTR);
         rf_wen_q   <= fire & (head.net_op == NET_REG);
         pc_wen_q   <= fire & (head.net_op == NET_PC);
         bar_wen_q  <= fire & (head.net_op == NET_BAR);
         if (fire & (head.net_op == NET_INSTR)) begin
            imem_addr_q <= head.net_addr;
            imem_data_q <= head.net_data[15:0];
         end
         if (fire & (head.net_op == NET_REG)) begin
            rf_addr_q <= head.net_addr[rd_size_gp-1:0];
            rf_data_q <= head.net_data;
         end
         if (fire & (head.net_op == NET_PC)) pc_q <= head.net_data[imem_addr_width_gp-1:0];
         if (fire & (head.net_op == NET_BAR)) bar_mask_q <= head.net_data[mask_length_gp-1:0];
         if (accept & ~enq & ~&drop_cnt_q) drop_cnt_q <= drop_cnt_q + DROP_CNT_W_P'(1);
      end
   end

   // Strobes are masked during reset so a dispatch registered just before it never escapes.
   assign imem_wen_o  = imem_wen_q & ~reset;
   assign rf_wen_o    = rf_wen_q & ~reset;
   assign pc_wen_o    = pc_wen_q & ~reset;
   assign bar_wen_o   = bar_wen_q & ~reset;
   assign imem_addr_o = imem_addr_q;
   assign imem_data_o = imem_data_q;
   assign rf_addr_o   = rf_addr_q;
   assign rf_data_o   = rf_data_q;
   assign pc_o        = pc_q;
   assign bar_mask_o  = bar_mask_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_net_packet_loader.sv
// tb_net_packet_loader: vector table plus scoreboard bench for net_packet_loader.
module tb_net_packet_loader;
   import net_packet_loader_pkg::*;

   typedef struct packed {
      logic [2:0]  kind;
      logic [9:0]  addr;
      logic [31:0] data;
   } exp_t;

   typedef struct packed {
      logic [18:0] id;
      logic [2:0]  op;
      logic [9:0]  addr;
      logic [31:0] data;
      exp_t        e;
   } vec_t;

   localparam logic [2:0] K_IMEM = 3'd0, K_RF = 3'd1, K_PC = 3'd2, K_BAR = 3'd3, K_DROP = 3'd4;
   localparam logic [18:0] C = 19'h00123;

   logic        clk = 1'b0;
   logic        reset;
   logic [18:0] core_id;
   state_e      state;
   logic        imem_wen, rf_wen, pc_wen, bar_wen;
   logic [9:0]  imem_addr, pc;
   logic [15:0] imem_data;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [2:0]  bar_mask;
   logic [7:0]  drop_cnt;

   exp_t        sb[$];
   exp_t        got;
   vec_t        tbl[10];
   int          n_tests = 0, n_fail = 0, strobe_cnt = 0, last_wait = 0;
   int          obs_n;
   logic [2:0]  obs_kind;
   logic [31:0] act_addr, act_data;

   always #5 clk = ~clk;

   net_packet_loader_if net_if();

   net_packet_loader dut (
      .clk         (clk),
      .reset       (reset),
      .core_id_i   (core_id),
      .state_i     (state),
      .net_if      (net_if.slave),
      .imem_wen_o  (imem_wen),
      .imem_addr_o (imem_addr),
      .imem_data_o (imem_data),
      .rf_wen_o    (rf_wen),
      .rf_addr_o   (rf_addr),
      .rf_data_o   (rf_data),
      .pc_wen_o    (pc_wen),
      .pc_o        (pc),
      .bar_wen_o   (bar_wen),
      .bar_mask_o  (bar_mask),
      .drop_cnt_o  (drop_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         obs_n = int'(imem_wen) + int'(rf_wen) + int'(pc_wen) + int'(bar_wen);
         if (obs_n != 0) strobe_cnt++;
         if (obs_n > 1) chk("one_strobe", obs_n, 1);
         else if (obs_n == 1) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_strobe: got imem=%0b rf=%0b pc=%0b bar=%0b expected none", imem_wen, rf_wen, pc_wen, bar_wen);
            end else begin
               got      = sb.pop_front();
               obs_kind = imem_wen ? K_IMEM : rf_wen ? K_RF : pc_wen ? K_PC : K_BAR;
               act_addr = imem_wen ? {22'd0, imem_addr} : rf_wen ? {27'd0, rf_addr} : 32'd0;
               act_data = imem_wen ? {16'd0, imem_data} : rf_wen ? rf_data : pc_wen ? {22'd0, pc} : {29'd0, bar_mask};
               chk("sb_kind", obs_kind, got.kind);
               chk("sb_addr", act_addr, {22'd0, got.addr});
               chk("sb_data", act_data, got.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [18:0] id, input logic [2:0] op, input logic [9:0] addr,
                       input logic [31:0] data, input exp_t e);
      logic acc = 1'b0;
      int   w   = 0;
      net_if.net_packet = '{id, op, addr, data};
      net_if.net_valid  = 1'b1;
      while (!acc && w < 40) begin
         @(negedge clk);
         acc = net_if.net_ready;
         w++;
         step();
      end
      net_if.net_valid = 1'b0;
      last_wait = w;
      chk("send_accept", acc, 1);
      if (acc && e.kind != K_DROP) sb.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      net_if.net_valid = 1'b0;
      step();
      reset = 1'b0;
      sb.delete();
   endtask

   int   s0, total, exp_drops;
   exp_t e6;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{C, 3'd2, 10'h003, 32'hDEADBEEF, '{K_RF, 10'h003, 32'hDEADBEEF}};
      tbl[1] = '{C, 3'd1, 10'h005, 32'h1234A5A5, '{K_IMEM, 10'h005, 32'h0000A5A5}};
      tbl[2] = '{C, 3'd3, 10'h1FF, 32'hFFFFF2AB, '{K_PC, 10'h000, 32'h000002AB}};
      tbl[3] = '{C, 3'd4, 10'h000, 32'h0000000D, '{K_BAR, 10'h000, 32'h00000005}};
      tbl[4] = '{19'h00122, 3'd2, 10'h001, 32'h1, '{K_DROP, 10'h0, 32'h0}};
      tbl[5] = '{C, 3'd0, 10'h001, 32'h2, '{K_DROP, 10'h0, 32'h0}};
      tbl[6] = '{C, 3'd5, 10'h001, 32'h3, '{K_DROP, 10'h0, 32'h0}};
      tbl[7] = '{C, 3'd7, 10'h001, 32'h4, '{K_DROP, 10'h0, 32'h0}};
      tbl[8] = '{C, 3'd2, 10'h3E7, 32'h00000000, '{K_RF, 10'h007, 32'h00000000}};
      tbl[9] = '{C, 3'd1, 10'h3FF, 32'hFFFFA5A5, '{K_IMEM, 10'h3FF, 32'h0000A5A5}};

      reset = 1'b1;
      state = IDLE;
      core_id = C;
      net_if.net_valid = 1'b0;
      net_if.net_packet = '0;
      idle(2);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", net_if.net_ready, 1);
      chk("rst_strobes", {imem_wen, rf_wen, pc_wen, bar_wen}, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_data", {imem_addr, imem_data, rf_addr}, 0);
      chk("rst_rf_data", rf_data, 0);
      step();

      // single REG: accepted in N, strobe in N+2
      net_if.net_packet = '{C, 3'd2, 10'h003, 32'hDEADBEEF};
      net_if.net_valid = 1'b1;
      sb.push_back('{K_RF, 10'h003, 32'hDEADBEEF});
      @(negedge clk);
      chk("t1_ready", net_if.net_ready, 1);
      step();
      net_if.net_valid = 1'b0;
      @(negedge clk);
      chk("t1_n1_rf_wen", rf_wen, 0);
      step();
      @(negedge clk);
      chk("t1_n2_rf_wen", rf_wen, 1);
      chk("t1_rf_addr", rf_addr, 3);
      chk("t1_rf_data", rf_data, 32'hDEADBEEF);
      chk("t1_others", {imem_wen, pc_wen, bar_wen}, 0);
      step();

      s0 = strobe_cnt;
      total = 0;
      for (int i = 0; i < 5; i++) begin
         send(C, 3'd2, 10'(i + 8), 32'hC0DE0000 + i, '{K_RF, 10'(i + 8), 32'hC0DE0000 + i});
         total += last_wait;
      end
      idle(5);
      chk("t2_no_backpressure", total, 5);
      chk("t2_strobes", strobe_cnt - s0, 5);
      chk("t2_drain", sb.size(), 0);

      s0 = drop_cnt;
      exp_drops = 0;
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].id, tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].e);
         if (tbl[i].e.kind == K_DROP) exp_drops++;
      end
      idle(6);
      chk("tbl_drain", sb.size(), 0);
      chk("tbl_drops", drop_cnt, s0 + exp_drops);

      state = RUN;
      send(C, 3'd1, 10'h3FF, 32'h0000A5A5, '{K_IMEM, 10'h3FF, 32'h0000A5A5});
      send(C, 3'd2, 10'h001, 32'h00000055, '{K_RF, 10'h001, 32'h00000055});
      s0 = strobe_cnt;
      idle(6);
      chk("t3_hold_quiet", strobe_cnt - s0, 0);
      state = IDLE;
      @(negedge clk);
      chk("t3_m_imem", imem_wen, 0);
      step();
      @(negedge clk);
      chk("t3_m1_imem", imem_wen, 1);
      chk("t3_m1_rf", rf_wen, 0);
      step();
      @(negedge clk);
      chk("t3_m2_rf", rf_wen, 1);
      chk("t3_m2_imem", imem_wen, 0);
      step();
      chk("t3_drain", sb.size(), 0);

      do_reset();
      s0 = strobe_cnt;
      send(19'h00122, 3'd2, 10'h0, 32'h0, '{K_DROP, 10'h0, 32'h0});
      send(19'h7FFF0, 3'd3, 10'h0, 32'h0, '{K_DROP, 10'h0, 32'h0});
      send(19'h00000, 3'd4, 10'h0, 32'h0, '{K_DROP, 10'h0, 32'h0});
      send(C, 3'd0, 10'h0, 32'h0, '{K_DROP, 10'h0, 32'h0});
      idle(3);
      chk("t4_drop4", drop_cnt, 4);
      chk("t4_no_strobe", strobe_cnt - s0, 0);
      for (int i = 0; i < 250; i++) send(19'h00001, 3'd2, 10'h0, 32'h0, '{K_DROP, 10'h0, 32'h0});
      idle(1);
      chk("t4_drop254", drop_cnt, 8'hFE);
      for (int i = 0; i < 50; i++) send(19'h00001, 3'd2, 10'h0, 32'h0, '{K_DROP, 10'h0, 32'h0});
      idle(1);
      chk("t4_drop_sat", drop_cnt, 8'hFF);

      do_reset();
      state = RUN;
      send(C, 3'd1, 10'h010, 32'h1111, '{K_IMEM, 10'h010, 32'h1111});
      for (int i = 0; i < 3; i++) send(C, 3'd2, 10'(i), 32'(i), '{K_RF, 10'(i), 32'(i)});
      s0 = strobe_cnt;
      net_if.net_packet = '{C, 3'd2, 10'h3, 32'h99};
      net_if.net_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_full_ready", net_if.net_ready, 0);
         step();
      end
      chk("t5_no_strobe", strobe_cnt - s0, 0);
      chk("t5_no_drop", drop_cnt, 0);
      reset = 1'b1;
      net_if.net_valid = 1'b0;
      state = IDLE;
      @(negedge clk);
      chk("t5_rst_cycle_strobes", {imem_wen, rf_wen, pc_wen, bar_wen}, 0);
      step();
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("t5_after_ready", net_if.net_ready, 1);
      chk("t5_after_strobes", {imem_wen, rf_wen, pc_wen, bar_wen}, 0);
      step();
      idle(5);
      chk("t5_no_stale", strobe_cnt - s0, 0);

      do_reset();
`ifdef NET_BROADCAST_EN
      e6 = '{K_PC, 10'h000, 32'h00000040};
`else
      e6 = '{K_DROP, 10'h000, 32'h00000000};
`endif
      send(19'h7FFFF, 3'd3, 10'h0, 32'h00000040, e6);
      idle(4);
      chk("t6_drain", sb.size(), 0);
      chk("t6_drop", drop_cnt, (e6.kind == K_DROP) ? 1 : 0);
      core_id = 19'h7FFFF;
      send(19'h7FFFF, 3'd2, 10'h005, 32'h00000077, '{K_RF, 10'h005, 32'h00000077});
      idle(4);
      chk("t6_self_bcast_drain", sb.size(), 0);
      chk("t6_self_bcast_drop", drop_cnt, (e6.kind == K_DROP) ? 1 : 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
